// File: rtl/decode_sequencer_if.sv
// Instruction / micro-op bus for decode_sequencer.
//   master : the sequencer (accepts instructions, issues register-file micro-ops)
//   slave  : the environment (offers instructions, consumes micro-ops)
// Signals:
//   in_valid/in_ready/instr       instruction handshake
//   uop_valid/uop_ready/uop_we    micro-op handshake and direction
//   nsel/readnum/writenum         register select (one-hot) and index
//   opcode/op/ALUop/shift         fields of the latched instruction
//   sximm5/sximm8                 sign-extended immediates (DW bits)
//   done/illegal                  completion / trap pulses
interface decode_sequencer_if #(
  parameter int unsigned DW = 16
) ();
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   instr;
  logic          uop_valid;
  logic          uop_ready;
  logic          uop_we;
  logic [2:0]    nsel;
  logic [2:0]    readnum;
  logic [2:0]    writenum;
  logic [2:0]    opcode;
  logic [1:0]    op;
  logic [1:0]    ALUop;
  logic [1:0]    shift;
  logic [DW-1:0] sximm5;
  logic [DW-1:0] sximm8;
  logic          done;
  logic          illegal;

  modport master (
    input  in_valid, instr, uop_ready,
    output in_ready, uop_valid, uop_we, nsel, readnum, writenum,
           opcode, op, ALUop, shift, sximm5, sximm8, done, illegal
  );

  modport slave (
    output in_valid, instr, uop_ready,
    input  in_ready, uop_valid, uop_we, nsel, readnum, writenum,
           opcode, op, ALUop, shift, sximm5, sximm8, done, illegal
  );
endinterface

// File: rtl/decode_sequencer.sv
// decode_sequencer: accepts a 16-bit instruction over a valid/ready handshake,
// latches it, and walks the register-file micro-ops it needs (read Rn, read
// Rm, read Rd, write) one handshake at a time, then pulses done.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      decode_sequencer_if.master (see interface file)
// Build option:
//   DECODE_ILLEGAL_TRAP_EN  defined  : unlisted encodings pulse illegal and
//                                      return to IDLE without done
//                           undefined: unlisted encodings act as NOP (done
//                                      only); illegal tied 0
module decode_sequencer #(
  parameter int unsigned DW = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  decode_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_RN  = 3'd1,
    S_RM  = 3'd2,
    S_RDR = 3'd3,
    S_WR  = 3'd4,
    S_FIN = 3'd5
  } state_t;

  // Which micro-ops an instruction needs; all-zero means unlisted encoding.
  typedef struct packed {
    logic rn;
    logic rm;
    logic rdr;
    logic wr;
  } plan_t;

  function automatic plan_t plan_of(input logic [4:0] opc_op);
    plan_t p;
    p = '0;
    case (opc_op)
      5'b110_10:          p.wr = 1'b1;                              // MOV-imm
      5'b110_00:          begin p.rm = 1'b1; p.wr = 1'b1; end       // MOV-reg
      5'b101_00,
      5'b101_10:          begin p.rn = 1'b1; p.rm = 1'b1; p.wr = 1'b1; end
      5'b101_01:          begin p.rn = 1'b1; p.rm = 1'b1; end       // CMP
      5'b101_11:          begin p.rm = 1'b1; p.wr = 1'b1; end       // MVN
      5'b011_00:          begin p.rn = 1'b1; p.wr = 1'b1; end       // LDR
      5'b100_00:          begin p.rn = 1'b1; p.rdr = 1'b1; end      // STR
      default:            p = '0;
    endcase
    return p;
  endfunction

  // Every sequence is an ordered subset of RN, RM, RDR, WR, so the next
  // state is the first needed micro-op after the current one.
  function automatic state_t step(input state_t from, input plan_t p);
    state_t nxt;
    nxt = S_FIN;
    if (p.wr  && (from inside {IDLE, S_RN, S_RM, S_RDR})) nxt = S_WR;
    if (p.rdr && (from inside {IDLE, S_RN, S_RM}))        nxt = S_RDR;
    if (p.rm  && (from inside {IDLE, S_RN}))              nxt = S_RM;
    if (p.rn  && (from == IDLE))                          nxt = S_RN;
    return nxt;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        in_ready_q, in_ready_d;
  logic        uop_valid_q, uop_valid_d;
  logic        uop_we_q, uop_we_d;
  logic [2:0]  nsel_q, nsel_d;
  logic [2:0]  num_q, num_d;
  logic        done_q, done_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        illegal_q, illegal_d;
`endif
  logic        accept;
  plan_t       plan_in;

  always_comb begin
    accept   = bus.in_valid & in_ready_q;
    plan_in  = plan_of(bus.instr[15:11]);
    state_d  = state_q;
    instr_d  = instr_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
    illegal_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          instr_d = bus.instr;
`ifdef DECODE_ILLEGAL_TRAP_EN
          if (plan_in == '0) begin
            state_d   = IDLE;
            illegal_d = 1'b1;
          end else begin
            state_d = step(IDLE, plan_in);
          end
`else
          // An empty plan steps straight to S_FIN: NOP with done only.
          state_d = step(IDLE, plan_in);
`endif
        end
      end
      S_RN, S_RM, S_RDR, S_WR: begin
        if (bus.uop_ready) state_d = step(state_q, plan_of(instr_q[15:11]));
      end
      S_FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered.
    in_ready_d  = (state_d == IDLE);
    uop_valid_d = (state_d inside {S_RN, S_RM, S_RDR, S_WR});
    uop_we_d    = (state_d == S_WR);
    done_d      = (state_d == S_FIN);
    nsel_d      = 3'b000;
    num_d       = 3'd0;
    case (state_d)
      S_RN:  begin nsel_d = 3'b100; num_d = instr_d[10:8]; end
      S_RM:  begin nsel_d = 3'b001; num_d = instr_d[2:0];  end
      S_RDR: begin nsel_d = 3'b010; num_d = instr_d[7:5];  end
      S_WR: begin
        // MOV-imm writes Rn; every other writer targets Rd.
        if (instr_d[15:11] == 5'b110_10) begin
          nsel_d = 3'b100;
          num_d  = instr_d[10:8];
        end else begin
          nsel_d = 3'b010;
          num_d  = instr_d[7:5];
        end
      end
      default: begin
        nsel_d = 3'b000;
        num_d  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      in_ready_q  <= 1'b0;
      uop_valid_q <= 1'b0;
      uop_we_q    <= 1'b0;
      nsel_q      <= '0;
      num_q       <= '0;
      done_q      <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      in_ready_q  <= in_ready_d;
      uop_valid_q <= uop_valid_d;
      uop_we_q    <= uop_we_d;
      nsel_q      <= nsel_d;
      num_q       <= num_d;
      done_q      <= done_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.uop_valid = uop_valid_q;
  assign bus.uop_we    = uop_we_q;
  assign bus.nsel      = nsel_q;
  assign bus.readnum   = num_q;
  assign bus.writenum  = num_q;
  assign bus.done      = done_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign bus.illegal   = illegal_q;
`else
  assign bus.illegal   = 1'b0;
`endif

  assign bus.opcode = instr_q[15:13];
  assign bus.op     = instr_q[12:11];
  assign bus.ALUop  = instr_q[12:11];
  assign bus.shift  = instr_q[4:3];
  assign bus.sximm5 = {{(DW-5){instr_q[4]}}, instr_q[4:0]};
  assign bus.sximm8 = {{(DW-8){instr_q[7]}}, instr_q[7:0]};

endmodule

// File: tb/tb_decode_sequencer.sv
// Self-checking bench for decode_sequencer: directed scenarios plus a
// randomized instruction stream checked against a table-driven model of the
// micro-op sequence each instruction should produce.
module tb_decode_sequencer;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  decode_sequencer_if #(.DW(DW)) bus ();
  decode_sequencer #(.DW(DW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef enum {M_MOVI, M_MOVR, M_ADD, M_AND, M_CMP, M_MVN, M_LDR, M_STR, M_BAD} mnem_t;
  typedef struct packed {
    logic       we;
    logic [2:0] nsel;
    logic [2:0] num;
  } uop_t;

  uop_t exp_q[$];

  function automatic mnem_t classify(input logic [15:0] i);
    logic [2:0] opc;
    logic [1:0] o;
    opc = i[15:13];
    o   = i[12:11];
    if (opc == 3'b110 && o == 2'b10) return M_MOVI;
    if (opc == 3'b110 && o == 2'b00) return M_MOVR;
    if (opc == 3'b101 && o == 2'b00) return M_ADD;
    if (opc == 3'b101 && o == 2'b10) return M_AND;
    if (opc == 3'b101 && o == 2'b01) return M_CMP;
    if (opc == 3'b101 && o == 2'b11) return M_MVN;
    if (opc == 3'b011 && o == 2'b00) return M_LDR;
    if (opc == 3'b100 && o == 2'b00) return M_STR;
    return M_BAD;
  endfunction

  task automatic expect_ops(input logic [15:0] i);
    uop_t rd_rn, rd_rm, rd_rd, wr_rd, wr_rn;
    rd_rn = {1'b0, 3'b100, i[10:8]};
    rd_rm = {1'b0, 3'b001, i[2:0]};
    rd_rd = {1'b0, 3'b010, i[7:5]};
    wr_rd = {1'b1, 3'b010, i[7:5]};
    wr_rn = {1'b1, 3'b100, i[10:8]};
    exp_q.delete();
    case (classify(i))
      M_MOVI: exp_q = '{wr_rn};
      M_MOVR: exp_q = '{rd_rm, wr_rd};
      M_ADD,
      M_AND:  exp_q = '{rd_rn, rd_rm, wr_rd};
      M_CMP:  exp_q = '{rd_rn, rd_rm};
      M_MVN:  exp_q = '{rd_rm, wr_rd};
      M_LDR:  exp_q = '{rd_rn, wr_rd};
      M_STR:  exp_q = '{rd_rn, rd_rd};
      default: exp_q.delete();
    endcase
  endtask

  // Two's-complement value of a 'bits'-wide field, truncated to DW bits.
  function automatic logic [31:0] sx(input int unsigned v, input int unsigned bits);
    int s;
    logic [DW-1:0] r;
    s = int'(v);
    if (v >= (32'd1 << (bits - 1))) s = s - int'(32'd1 << bits);
    r = DW'(s);
    return 32'(r);
  endfunction

  task automatic check_fields(input string pfx, input logic [15:0] i);
    check({pfx, "_opcode"}, 32'(bus.opcode), 32'(i[15:13]));
    check({pfx, "_op"},     32'(bus.op),     32'(i[12:11]));
    check({pfx, "_aluop"},  32'(bus.ALUop),  32'(i[12:11]));
    check({pfx, "_shift"},  32'(bus.shift),  32'(i[4:3]));
    check({pfx, "_sximm5"}, 32'(bus.sximm5), sx(32'(i[4:0]), 5));
    check({pfx, "_sximm8"}, 32'(bus.sximm8), sx(32'(i[7:0]), 8));
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_in_ready"},  32'(bus.in_ready),  0);
    check({pfx, "_uop_valid"}, 32'(bus.uop_valid), 0);
    check({pfx, "_uop_we"},    32'(bus.uop_we),    0);
    check({pfx, "_nsel"},      32'(bus.nsel),      0);
    check({pfx, "_readnum"},   32'(bus.readnum),   0);
    check({pfx, "_writenum"},  32'(bus.writenum),  0);
    check({pfx, "_done"},      32'(bus.done),      0);
    check({pfx, "_illegal"},   32'(bus.illegal),   0);
    check_fields(pfx, 16'h0000);
  endtask

  // mode 0: uop_ready always 1; mode 1: random uop_ready;
  // mode 2: first micro-op stalled exactly 3 cycles, then always ready.
  // hold: leave in_valid at 1 after acceptance.
  task automatic run_instr(input logic [15:0] i, input int mode, input bit hold,
                           output int waits);
    bit rdy;
    int stalls;
    expect_ops(i);
    bus.in_valid = 1'b1;
    bus.instr    = i;
    waits = 0;
    while (bus.in_ready !== 1'b1 && waits < 20) begin
      if (mode == 1) bus.uop_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      waits++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("accept_timeout", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
    check_fields("acc", i);
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (classify(i) == M_BAD) begin
      check("trap_illegal",   32'(bus.illegal),   1);
      check("trap_done",      32'(bus.done),      0);
      check("trap_uop_valid", 32'(bus.uop_valid), 0);
      check("trap_in_ready",  32'(bus.in_ready),  1);
      return;
    end
`endif
    foreach (exp_q[k]) begin
      stalls = 0;
      forever begin
        check("uop_valid",    32'(bus.uop_valid), 1);
        check("uop_nsel",     32'(bus.nsel),      32'(exp_q[k].nsel));
        check("uop_readnum",  32'(bus.readnum),   32'(exp_q[k].num));
        check("uop_writenum", 32'(bus.writenum),  32'(exp_q[k].num));
        check("uop_we",       32'(bus.uop_we),    32'(exp_q[k].we));
        check("uop_in_ready", 32'(bus.in_ready),  0);
        check("uop_done",     32'(bus.done),      0);
        check("uop_illegal",  32'(bus.illegal),   0);
        case (mode)
          0:       rdy = 1'b1;
          2:       rdy = (k != 0) || (stalls >= 3);
          default: rdy = ($urandom_range(0, 1) == 1) || (stalls >= 4);
        endcase
        bus.uop_ready = rdy;
        @(negedge clk);
        if (rdy) break;
        stalls++;
      end
    end
    if (mode == 1) bus.uop_ready = 1'($urandom_range(0, 1));
    else           bus.uop_ready = 1'b0;
    check("fin_done",      32'(bus.done),      1);
    check("fin_uop_valid", 32'(bus.uop_valid), 0);
    check("fin_nsel",      32'(bus.nsel),      0);
    check("fin_readnum",   32'(bus.readnum),   0);
    check("fin_in_ready",  32'(bus.in_ready),  0);
    check("fin_illegal",   32'(bus.illegal),   0);
    check_fields("fin", i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int n;
    logic [4:0] prefixes [8];
    logic [15:0] ri;
    prefixes = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_10,
                 5'b101_01, 5'b101_11, 5'b011_00, 5'b100_00};

    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.uop_ready = 1'b0;
    reset_n       = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", 32'(bus.in_ready), 1);

    // ADD r5 = r0 + r1, always ready
    run_instr(16'hA0A1, 0, 1'b0, w);
    // MOV-imm r7 = -8
    run_instr(16'hD7F8, 0, 1'b0, w);
    // CMP with first read stalled three cycles
    run_instr(16'hA900, 2, 1'b0, w);

    // Back-to-back MOV-imm with in_valid held high
    run_instr(16'hD385, 0, 1'b1, w);
    run_instr(16'hD1F0, 0, 1'b0, n);
    check("b2b_accept_wait", 32'(n), 1);

    // Reset in the middle of an ADD, while in the Rm read
    bus.in_valid  = 1'b1;
    bus.instr     = 16'hA0A1;
    bus.uop_ready = 1'b0;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_accept", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid_rst_rn_nsel", 32'(bus.nsel), 32'(3'b100));
    bus.uop_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_rm_nsel", 32'(bus.nsel), 32'(3'b001));
    bus.uop_ready = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_rst");
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(bus.in_ready), 1);
    check("mid_rst_no_done",  32'(bus.done),     0);

    // Unlisted encoding
    run_instr(16'hE000, 0, 1'b0, w);
    @(negedge clk);
    check("bad_after_illegal", 32'(bus.illegal), 0);
    check("bad_after_done",    32'(bus.done),    0);

    // Randomized stream: mostly listed encodings, some arbitrary words
    for (int t = 0; t < 80; t++) begin
      n = int'($urandom_range(0, 8));
      ri = 16'($urandom);
      if (n < 8) ri[15:11] = prefixes[n];
      run_instr(ri, 1, 1'($urandom_range(0, 1)), w);
    end
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("end_idle_in_ready",  32'(bus.in_ready),  1);
    check("end_idle_uop_valid", 32'(bus.uop_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 Parameter DW, default 16: width of sximm5/sximm8 outputs; legal range 8..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  instruction offered.
REQ-005 in_ready  output  1  sequencer can accept an instruction.
REQ-006 instr  input  16  instruction word; fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], shift[4:3], Rm[2:0], imm8[7:0], imm5[4:0].
REQ-007 uop_valid  output  1  register-file micro-op presented.
REQ-008 uop_ready  input  1  micro-op consumed this cycle.
REQ-009 uop_we  output  1  1 = write micro-op, 0 = read micro-op.
REQ-010 nsel  output  3  one-hot register select: 001 Rm, 010 Rd, 100 Rn, 000 none.
REQ-011 readnum, writenum  output  3 each  register index selected by nsel; both carry the same value; 0 when nsel=000.
REQ-012 opcode 3, op 2, ALUop 2, shift 2  outputs  fields of the latched instruction.
REQ-013 sximm5, sximm8  output  DW each  imm5/imm8 of the latched instruction, sign-extended.
REQ-014 done  output  1  one-cycle pulse: instruction fully sequenced.
REQ-015 illegal  output  1  one-cycle pulse: unsupported encoding (see REQ-030).

Function
REQ-016 States: IDLE, S_RN, S_RM, S_RDR (read Rd), S_WR, S_FIN; state register is encoded.
REQ-017 in_ready = 1 only in IDLE; accept = in_valid & in_ready latches instr into an internal register.
REQ-018 Field and immediate outputs derive from the latched register only; they hold stable from accept until the next accept.
REQ-019 Latency: the first micro-op appears on uop_valid in the cycle after accept.
REQ-020 In a micro-op state, uop_valid = 1 and nsel/uop_we/readnum are stable until the cycle where uop_ready = 1; the next state is taken on that edge.
REQ-021 uop_ready while uop_valid = 0 is ignored.
REQ-022 Micro-op sequences, by opcode/op:
- 110/10 MOV-imm: S_WR(Rn).
- 110/00 MOV-reg: S_RM, S_WR(Rd).
- 101/00 ADD, 101/10 AND: S_RN, S_RM, S_WR(Rd).
- 101/01 CMP: S_RN, S_RM.
- 101/11 MVN: S_RM, S_WR(Rd).
- 011/00 LDR: S_RN, S_WR(Rd).
- 100/00 STR: S_RN, S_RDR.
REQ-023 The nsel value in S_WR is 100 for MOV-imm and 010 otherwise.
REQ-024 After the last micro-op handshake, the FSM enters S_FIN; there done = 1 and the FSM moves to IDLE next cycle.
REQ-025 S_FIN lasts exactly one cycle; an instruction may be accepted in the IDLE cycle immediately after it (throughput = uops + 2 cycles).
REQ-026 sximm8 = {(DW-8){imm8[7]}, imm8}; sximm5 = {(DW-5){imm5[4]}, imm5}.
REQ-027 in_valid while not in IDLE is ignored; the instruction is not lost if the source holds it (standard valid/ready).
REQ-028 uop_valid = 0, nsel = 000 in IDLE and S_FIN.

Reset
REQ-029 While reset_n = 0 at a rising edge, the following clear to 0 on that edge: state = IDLE, latched instruction, all outputs, and in_ready; in_ready rises in the first cycle after reset_n = 1. A reset mid-sequence abandons the instruction without a done pulse.

Configuration
REQ-030 Macro DECODE_ILLEGAL_TRAP_EN; an unlisted opcode/op combination is handled as follows:
- defined: accept -> IDLE next cycle, with illegal = 1 for that one cycle and no done.
- undefined: treated as NOP: accept -> S_FIN (done = 1, no micro-ops); the illegal output is tied 0.

Verification
REQ-031 ADD 0xA0A1 (Rn=0, Rd=5, Rm=1), uop_ready = 1 -> nsel 100/001/010, readnum 0/1/5, uop_we 0/0/1 on consecutive cycles, then done.
REQ-032 MOV-imm 0xD7F8 with DW=16 -> single write with nsel = 100, writenum = 7, sximm8 = 0xFFF8.
REQ-033 CMP 0xA900 with uop_ready held 0 for 3 cycles -> nsel = 100 held stable for all 3 cycles, no advance, in_ready = 0.
REQ-034 Back-to-back MOV-imm instructions with in_valid held 1 -> second accept in the cycle after done; no instruction dropped.
REQ-035 Reset asserted during S_RM of an ADD -> next cycle: all outputs 0, no done; in_ready = 1 after release.
REQ-036 Instruction 0xE000 -> with macro: illegal pulse, no done, no micro-ops; without macro: done pulse only.
